// File: rtl/rs232_pkg.sv
// rs232_pkg: 8N1 frame constants, FSM state encoding and baud divider shared by the RS232 tx/rx paths.
package rs232_pkg;
    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    function automatic int div_calc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/rs232_tx_fifo.sv
// tx_fifo: synchronous byte FIFO with registered full/empty, a count and a drop-on-full write.
module tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [7:0] data,
    input  logic       rd,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count, count_nxt;
    logic          push, pull;

    assign push      = wr && !full;
    assign pull      = rd && !empty;
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pull);
    assign head      = mem[rp];

    always_ff @(posedge clk)
        if (push) mem[wp] <= data;

    // Flags are computed from the next count so they are registered yet current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pull);
            count <= count_nxt;
            full  <= count_nxt == (AW+1)'(DEPTH);
            empty <= count_nxt == '0;
            ovf   <= ovf | (wr && full);
        end
    end
endmodule

// File: rtl/rs232_tx.sv
// rs232_tx: FIFO-buffered 8N1 serial transmitter with back-to-back frame support.
module rs232_tx
    import rs232_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLK_50MHZ,
    input  logic       RST_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_WR,
    output logic       TX_FULL,
    output logic       TX_EMPTY,
    output logic       TX_BUSY,
    output logic       TX_OVF,
    output logic       RS232_DCE_TXD
);
    localparam int DIV = div_calc(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift, head;
    logic          bit_end, pop;

    assign bit_end = cnt == CW'(DIV - 1);
    assign pop     = !TX_EMPTY && (state == IDLE || (state == STOP && bit_end));
    assign TX_BUSY = state != IDLE;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK_50MHZ),
        .rst_n (RST_N),
        .wr    (TX_WR),
        .data  (TX_DATA),
        .rd    (pop),
        .head  (head),
        .full  (TX_FULL),
        .empty (TX_EMPTY),
        .ovf   (TX_OVF)
    );

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            RS232_DCE_TXD <= IDLE_LVL;
        end else begin
            cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
            case (state)
                IDLE:
                    if (pop) begin
                        shift         <= head;
                        state         <= START;
                        RS232_DCE_TXD <= START_LVL;
                    end
                START:
                    if (bit_end) begin
                        state         <= DATA;
                        bit_idx       <= '0;
                        RS232_DCE_TXD <= shift[0];
                    end
                DATA:
                    if (bit_end) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state         <= STOP;
                            RS232_DCE_TXD <= STOP_LVL;
                        end else begin
                            shift         <= shift >> 1;
                            bit_idx       <= bit_idx + 3'd1;
                            RS232_DCE_TXD <= shift[1];
                        end
                    end
                STOP:
                    if (pop) begin
                        shift         <= head;
                        state         <= START;
                        RS232_DCE_TXD <= START_LVL;
                    end else if (bit_end) begin
                        state         <= IDLE;
                        RS232_DCE_TXD <= IDLE_LVL;
                    end
            endcase
        end
    end
endmodule
